// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, single-outstanding word fetch, small fetch FIFO to decode, redirect with flush.
// Optional IFU_PERF_CNT_EN adds Fetch_Count / Stall_Count performance counters.
module instruction_fetch_unit #(
    parameter int                ADDR_W     = 64,
    parameter int                INST_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] Inst_Address,
    output logic              Mem_Req,
    input  logic              Mem_Ack,
    input  logic [INST_W-1:0] Instruction,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] Redirect_PC,
    input  logic              Stall,
    output logic              IF_Valid,
    output logic [INST_W-1:0] IF_Instruction,
    output logic [ADDR_W-1:0] IF_PC
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       Fetch_Count,
    output logic [31:0]       Stall_Count
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    entry_t            fifo_q [FIFO_DEPTH];
    entry_t            fifo_d [FIFO_DEPTH];

    logic              push, pop, new_req;
    logic [CNT_W-1:0]  cnt_after;
    logic [ADDR_W-1:0] redir_pc;

    assign redir_pc = Redirect_PC & ~ADDR_W'(3);
    assign IF_Valid = (cnt_q != '0);

    // Redirect kills both the same-cycle push and pop; the FIFO is flushed anyway.
    always_comb begin
        push      = (state_q == S_REQ) && Mem_Ack && !Redirect;
        pop       = IF_Valid && !Stall && !Redirect;
        cnt_after = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (Redirect || cnt_q < DEPTH_C) state_d = S_REQ;
            S_REQ: begin
                if (Redirect)                            state_d = Mem_Ack ? S_REQ : S_DRAIN;
                else if (Mem_Ack && cnt_after >= DEPTH_C) state_d = S_IDLE;
            end
            S_DRAIN: if (Mem_Ack) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    // A fresh request always targets the updated pc, so redirect targets and pc+4 fall out alike.
    always_comb begin
        new_req  = (state_d == S_REQ) && ((state_q == S_IDLE) || Mem_Ack);
        pc_d     = Redirect ? redir_pc : (push ? pc_q + ADDR_W'(4) : pc_q);
        addr_d   = new_req ? pc_d : addr_q;
        req_d    = (state_d != S_IDLE);
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_after;
        if (Redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = '{pc: pc_q, inst: Instruction};
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            req_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            fifo_q   <= fifo_d;
        end
    end

    assign Inst_Address   = addr_q;
    assign Mem_Req        = req_q;
    assign IF_Instruction = IF_Valid ? fifo_q[rd_ptr_q].inst : '0;
    assign IF_PC          = IF_Valid ? fifo_q[rd_ptr_q].pc   : '0;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(push);
        stall_cnt_d = stall_cnt_q + 32'(IF_Valid && Stall);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Fetch_Count = fetch_cnt_q;
    assign Stall_Count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory model with variable ack latency, program-order
// scoreboard of expected PCs, directed latency/stall/drain/redirect/reset cases, then random traffic.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] Inst_Address;
    logic        Mem_Req;
    logic        Mem_Ack;
    logic [31:0] Instruction;
    logic        Redirect;
    logic [63:0] Redirect_PC;
    logic        Stall;
    logic        IF_Valid;
    logic [31:0] IF_Instruction;
    logic [63:0] IF_PC;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] Fetch_Count, Stall_Count;
`endif

    instruction_fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .Inst_Address(Inst_Address), .Mem_Req(Mem_Req),
        .Mem_Ack(Mem_Ack), .Instruction(Instruction), .Redirect(Redirect), .Redirect_PC(Redirect_PC),
        .Stall(Stall), .IF_Valid(IF_Valid), .IF_Instruction(IF_Instruction), .IF_PC(IF_PC)
`ifdef IFU_PERF_CNT_EN
        , .Fetch_Count(Fetch_Count), .Stall_Count(Stall_Count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_next;
    int  fix_delay = 0;
    bit  rand_delay = 1'b0;
    int  wcnt = 0;
    int  cur_delay = 0;
    int  hs_cnt = 0;
    int  st_cnt = 0;

    function automatic logic [31:0] memf(input logic [63:0] a);
        return 32'h0040_0093 ^ {a[29:0], 2'b00} ^ a[63:32] ^ {a[9:2], 24'h0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Program order: after reset or a redirect, decode sees target, target+4, ... (mod 2^64).
    function automatic void model_refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 64'd4;
        end
    endfunction

    function automatic void model_restart(input logic [63:0] target);
        exp_q.delete();
        exp_next = target & ~64'h3;
        model_refill();
    endfunction

    function automatic int pick_delay();
        return rand_delay ? int'($urandom_range(0, 3)) : fix_delay;
    endfunction

    // Instruction memory: acks each request after cur_delay waiting cycles.
    initial begin
        Mem_Ack = 1'b0;
        Instruction = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                Mem_Ack = 1'b0;
                wcnt = 0;
                cur_delay = pick_delay();
            end else begin
                if (Mem_Ack) begin
                    wcnt = 0;
                    cur_delay = pick_delay();
                end
                if (Mem_Req && wcnt >= cur_delay) begin
                    Mem_Ack = 1'b1;
                    Instruction = memf(Inst_Address);
                end else begin
                    Mem_Ack = 1'b0;
                    Instruction = $urandom;
                    if (Mem_Req) wcnt++;
                end
            end
        end
    end

    // Monitor: pops scoreboard on every accepted instruction, checks request stability and flush.
    initial begin
        bit          pend = 1'b0;
        bit          prev_redir = 1'b0;
        logic [63:0] pend_addr = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!reset_n) begin
                pend = 1'b0;
                prev_redir = 1'b0;
                hs_cnt = 0;
                st_cnt = 0;
            end else begin
                if (pend) begin
                    check("req_hold", 64'(Mem_Req), 64'd1);
                    check("addr_hold", Inst_Address, pend_addr);
                end
                if (prev_redir) check("flush_valid", 64'(IF_Valid), 64'd0);
                if (IF_Valid && !Stall && !Redirect && exp_q.size() > 0) begin
                    check("if_pc", IF_PC, exp_q[0]);
                    check("if_inst", 64'(IF_Instruction), 64'(memf(exp_q[0])));
                    void'(exp_q.pop_front());
                    model_refill();
                end
                if (Mem_Req && Mem_Ack) hs_cnt++;
                if (IF_Valid && Stall) st_cnt++;
                pend = Mem_Req && !Mem_Ack;
                pend_addr = Inst_Address;
                prev_redir = Redirect;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] hold_pc;
        bit          found;
        Stall = 1'b0;
        Redirect = 1'b0;
        Redirect_PC = '0;
        model_restart(64'h0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", 64'(Mem_Req), 64'd0);
        check("rst_addr", Inst_Address, 64'h0);
        check("rst_valid", 64'(IF_Valid), 64'd0);
        check("rst_pc", IF_PC, 64'h0);
        check("rst_inst", 64'(IF_Instruction), 64'h0);

        // Release in cycle 0: request in cycle 1, first instruction in cycle 2, then 1 per cycle.
        @(negedge clk);
        reset_n = 1'b1;
        #4 check("c0_req", 64'(Mem_Req), 64'd0);
        @(negedge clk);
        #4 check("c1_req", 64'(Mem_Req), 64'd1);
        check("c1_addr", Inst_Address, 64'h0);
        check("c1_valid", 64'(IF_Valid), 64'd0);
        @(negedge clk);
        #4 check("c2_valid", 64'(IF_Valid), 64'd1);
        check("c2_pc", IF_PC, 64'h0);
        check("c2_inst", 64'(IF_Instruction), 64'h0040_0093);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #4 check("thru_valid", 64'(IF_Valid), 64'd1);
        end

        // Hold Stall 4 cycles: FIFO fills, fetching stops, head held.
        @(negedge clk);
        Stall = 1'b1;
        #4 hold_pc = IF_PC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #4 check("stall_pc", IF_PC, hold_pc);
        end
        check("stall_req", 64'(Mem_Req), 64'd0);
        check("stall_valid", 64'(IF_Valid), 64'd1);
        @(negedge clk);
        Stall = 1'b0;
        repeat (6) @(negedge clk);

        // Reset in the middle of a request: outputs drop with no clock edge.
        #1 check("mid_req_before", 64'(Mem_Req), 64'd1);
        #1 reset_n = 1'b0;
        #1 check("mid_rst_req", 64'(Mem_Req), 64'd0);
        check("mid_rst_valid", 64'(IF_Valid), 64'd0);
        check("mid_rst_addr", Inst_Address, 64'h0);
        model_restart(64'h0);
        fix_delay = 2;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #4 check("rel_req", 64'(Mem_Req), 64'd1);
        check("rel_addr", Inst_Address, 64'h0);

        // Redirect to 0x40 while slow fetch of 0x8 is pending: address held, word discarded.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #1;
            if (Mem_Req && !Mem_Ack && Inst_Address == 64'h8) found = 1'b1;
        end
        check("find_req8", 64'(found), 64'd1);
        Redirect = 1'b1;
        Redirect_PC = 64'h40;
        model_restart(64'h40);
        @(negedge clk);
        Redirect = 1'b0;
        #1 check("drain_addr", Inst_Address, 64'h8);
        check("drain_req", 64'(Mem_Req), 64'd1);
        fix_delay = 0;
        repeat (12) @(negedge clk);

        // Redirect to 0x43 coinciding with an ack: acked word dropped, refetch at 0x40.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            if (Mem_Req && Mem_Ack) found = 1'b1;
        end
        check("find_ack", 64'(found), 64'd1);
        Redirect = 1'b1;
        Redirect_PC = 64'h43;
        model_restart(64'h43);
        @(negedge clk);
        Redirect = 1'b0;
        #1 check("r43_addr", Inst_Address, 64'h40);
        check("r43_req", 64'(Mem_Req), 64'd1);
        repeat (6) @(negedge clk);

        // PC wraps past the top of the address space.
        Redirect = 1'b1;
        Redirect_PC = 64'hFFFF_FFFF_FFFF_FFF8;
        model_restart(64'hFFFF_FFFF_FFFF_FFF8);
        @(negedge clk);
        Redirect = 1'b0;
        repeat (8) @(negedge clk);

`ifdef IFU_PERF_CNT_EN
        reset_n = 1'b0;
        model_restart(64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        Stall = 1'b1;
        repeat (3) @(negedge clk);
        Stall = 1'b0;
        repeat (6) @(negedge clk);
        #3 check("fetch_count", 64'(Fetch_Count), 64'(hs_cnt));
        check("stall_count", 64'(Stall_Count), 64'(st_cnt));
        check("stall_count_3", 64'(Stall_Count), 64'd3);
`endif

        rand_delay = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            Stall = ($urandom_range(0, 3) == 0);
            Redirect = ($urandom_range(0, 24) == 0);
            if (Redirect) begin
                Redirect_PC = {$urandom, $urandom};
                model_restart(Redirect_PC);
            end
        end
        @(negedge clk);
        Stall = 1'b0;
        Redirect = 1'b0;
        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
